// File: rtl/periph_bus_ctrl.sv
// Data-bus controller: registered request/acknowledge access to N slaves
// with wait states, bounded timeout, bus errors and per-slave read-done.
module periph_bus_ctrl #(
    parameter int                NUM_SLAVES  = 4,
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                REGION_BITS = 8,
    parameter int                TIMEOUT     = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req,
    input  logic                         write_enable,
    input  logic [DATA_W/8-1:0]          byte_enable,
    input  logic [ADDR_W-1:0]            address,
    input  logic [DATA_W-1:0]            write_data,
    output logic [DATA_W-1:0]            read_data,
    output logic                         ready,
    output logic                         error,
    output logic [NUM_SLAVES-1:0]        s_req,
    output logic                         s_write_enable,
    output logic [DATA_W/8-1:0]          s_byte_enable,
    output logic [REGION_BITS-1:0]       s_address,
    output logic [DATA_W-1:0]            s_write_data,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ack,
    output logic [NUM_SLAVES-1:0]        s_read_done
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [ADDR_W-1:0] NUM_A     = ADDR_W'(NUM_SLAVES);
    localparam logic [7:0]        TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [BE_W-1:0]        be_q, be_d;
    logic [REGION_BITS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   ready_q, ready_d;
    logic                   error_q, error_d;
    logic [NUM_SLAVES-1:0]  s_req_q, s_req_d;
    logic [NUM_SLAVES-1:0]  done_q, done_d;

    logic [ADDR_W-1:0]     offset;
    logic [ADDR_W-1:0]     region;
    logic                  mapped;
    logic [IDX_W-1:0]      req_idx;
    logic [NUM_SLAVES-1:0] req_oh;
    logic [NUM_SLAVES-1:0] cur_oh;
    logic                  ack_sel;
    logic [DATA_W-1:0]     rdata_sel;

    // Underflow is judged by compare; region index keeps all upper bits.
    assign offset  = address - BASE_ADDR;
    assign region  = offset >> REGION_BITS;
    assign mapped  = (address >= BASE_ADDR) && (region < NUM_A);
    assign req_idx = region[IDX_W-1:0];

    always_comb begin
        req_oh    = '0;
        cur_oh    = '0;
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (req_idx == IDX_W'(i)) begin
                req_oh[i] = 1'b1;
            end
            if (idx_q == IDX_W'(i)) begin
                cur_oh[i] = 1'b1;
                ack_sel   = s_ack[i];
                rdata_sel = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = '0;
        ready_d = 1'b0;
        error_d = 1'b0;
        s_req_d = s_req_q;
        done_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = write_enable;
                    be_d    = byte_enable;
                    addr_d  = offset[REGION_BITS-1:0];
                    wdata_d = write_data;
                    if (!mapped) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        idx_d   = req_idx;
                        cnt_d   = 8'd0;
                        s_req_d = req_oh;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // Ack wins over an expiring counter on the same cycle.
                if (ack_sel) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    s_req_d = '0;
                    if (!we_q) begin
                        rdata_d = rdata_sel;
                        done_d  = cur_oh;
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    s_req_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                s_req_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            s_req_q <= '0;
            done_q  <= '0;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
            s_req_q <= s_req_d;
            done_q  <= done_d;
        end
    end

    assign read_data      = rdata_q;
    assign ready          = ready_q;
    assign error          = error_q;
    assign s_req          = s_req_q;
    assign s_write_enable = we_q;
    assign s_byte_enable  = be_q;
    assign s_address      = addr_q;
    assign s_write_data   = wdata_q;
    assign s_read_done    = done_q;

endmodule

// File: doc/periph_bus_ctrl.md
# periph_bus_ctrl

Parametrised data-bus controller between the core's data port and N memory-mapped slaves (RAM, diodes, keyboard, future peripherals). It replaces pure combinational address decoding with a registered request/acknowledge transaction, so slaves may insert wait states. It bounds every access with a timeout and flags unmapped or timed-out accesses as bus errors. It emits a per-slave read-done pulse, the generalised form of the keyboard "data consumed" signal.

## Interface
- NUM_SLAVES, 4, number of slave channels (1..16)
- DATA_W, 32, data width in bits (multiple of 8)
- ADDR_W, 32, address width
- BASE_ADDR, 0, byte address of slave 0's region
- REGION_BITS, 8, log2 of region size in bytes; slave i owns [BASE_ADDR + i*2^REGION_BITS, BASE_ADDR + (i+1)*2^REGION_BITS)
- TIMEOUT, 15, max wait cycles in ACCESS before error (1..255)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  master request (sampled only in IDLE)
- write_enable  in  1  1 = write, 0 = read
- byte_enable  in  DATA_W/8  byte lanes for writes
- address  in  ADDR_W  byte address
- write_data  in  DATA_W  write data
- read_data  out  DATA_W  response data, valid while ready=1
- ready  out  1  one-cycle transaction-complete pulse
- error  out  1  qualifies ready: access was unmapped or timed out
- s_req  out  NUM_SLAVES  one-hot slave select, held through ACCESS
- s_write_enable  out  1  latched write_enable, shared
- s_byte_enable  out  DATA_W/8  latched byte_enable, shared
- s_address  out  REGION_BITS  latched address offset within region, shared
- s_write_data  out  DATA_W  latched write_data, shared
- s_rdata  in  NUM_SLAVES*DATA_W  slave i data on bits [i*DATA_W +: DATA_W]
- s_ack  in  NUM_SLAVES  slave i acknowledge; may be combinational from s_req
- s_read_done  out  NUM_SLAVES  one-cycle pulse to slave i after a successful read

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: when req=1, latch write_enable, byte_enable, address offset and write_data. Compute idx = (address - BASE_ADDR) >> REGION_BITS.
  - If address < BASE_ADDR or idx >= NUM_SLAVES, go to RESP with error=1. No s_req is asserted.
  - Otherwise store idx, clear wait counter and go to ACCESS.
- ACCESS: s_req[idx]=1, all other bits 0. Shared slave outputs hold the latched values.
  - If s_ack[idx]=1, capture s_rdata[idx] (reads only) and go to RESP with error=0.
  - Else if wait counter == TIMEOUT, go to RESP with error=1.
  - Else increment wait counter.
  - s_ack bits other than idx are ignored.
- RESP: ready=1 for exactly one cycle.
  - read_data = captured data on a successful read; 0 on error or write.
  - s_read_done[idx]=1 this cycle only on a successful read.
  - Next state is always IDLE. req is not sampled in RESP.
- Address subtraction is done at ADDR_W bits. The underflow check uses a compare, not the wrapped result. The idx compare uses the full shifted value, not a truncated value.
- Reset, from any state including mid-ACCESS: state=IDLE, counter=0, and all outputs 0 (read_data, ready, error, s_req, s_read_done, shared slave outputs). An aborted access is never acknowledged to the master.

## Timing
- Request accepted in IDLE cycle T0. s_req asserted from T0+1.
- Zero-wait slave (ack in first ACCESS cycle): ready at T0+2.
- k wait cycles: ready at T0+2+k.
- Timeout: ACCESS lasts TIMEOUT+1 cycles, so error/ready come at T0+TIMEOUT+2.
- Unmapped access: ready+error at T0+1.
- Back-to-back: the earliest next acceptance is the cycle after RESP. The master holds req, and it is re-sampled in IDLE.
- An ack arriving on the same edge the counter reaches TIMEOUT counts as success, because ack has priority.
- All outputs are registered except the s_* fields, which are direct register outputs too. There are no combinational input-to-output paths.

## Test plan
- Reset, then read slave 1 at BASE_ADDR+0x104 with a zero-wait ack and s_rdata[1]=0x12345678 -> s_req=4'b0010 and s_address=0x04 at T0+1. ready=1, error=0, read_data=0x12345678 and s_read_done=4'b0010 at T0+2, each for one cycle.
- Write 0xA5A5A5A5 with byte_enable=4'b0011 to slave 2; ack delayed 3 cycles -> shared outputs stable for 4 ACCESS cycles. ready at T0+5, read_data=0, s_read_done=0.
- Read slave 0 with no ack, TIMEOUT=15 -> s_req held 16 cycles. ready=1, error=1, read_data=0 at T0+17, and no s_read_done.
- Address BASE_ADDR+NUM_SLAVES*2^REGION_BITS, plus BASE_ADDR=0x1000 with address 0xFFC -> each gives ready+error at T0+1 with s_req never asserted.
- Ack at exactly the TIMEOUT-th wait cycle -> success, error=0. Req held high continuously -> transactions repeat every 3 cycles (zero-wait).
- Assert reset during ACCESS of slave 3 -> the next cycle has all outputs 0 and state IDLE. A later ack from slave 3 produces no ready.
